// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, opcode encoding and the MEM-stage access FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDIU = 6'h09,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B,
      OP_HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HALTED = 2'd2
   } mem_acc_state_t;

   function automatic logic is_mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max_o flags that the value after this
// cycle's update equals max_i, so a caller can register the event on the same edge.
module sat_counter #(
   parameter int W = 9
) (
   input  logic         clk_i,
   input  logic         nrst_i,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] max_i,
   output logic         at_max_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != max_i)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   assign at_max_o = (cnt_d == max_i);

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: issues one load/store to the dcache, holds it until dhit,
// and feeds the MEM/WB latch. Stalls the front of the pipe while a request is outstanding.
//
// state  | meaning
// IDLE   | no request outstanding; accepts the next EX/MEM instruction
// ACCESS | request driven to dcache, waiting for dhit (watchdog running)
// HALTED | HALT retired; absorbing until reset
module mem_access_unit
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        ex_valid_i,
   input  logic        ex_memRd_i,
   input  logic        ex_memWr_i,
   input  logic [31:0] ex_addr_i,
   input  logic [31:0] ex_wdat_i,
   input  logic        ex_halt_i,
   input  logic        dhit_i,
   input  logic [31:0] dcache_load_i,
   output logic        dmemREN_o,
   output logic        dmemWEN_o,
   output logic [31:0] dmemaddr_o,
   output logic [31:0] dmemstore_o,
   output logic [31:0] dmemload_in_o,
   output logic        wb_valid_o,
   output logic        mem_stall_o,
   output logic        halt_in_o,
   output logic        mem_err_o
);

   mem_acc_state_t state_q, state_d;
   logic  ren_q, ren_d;
   logic  wen_q, wen_d;
   word_t addr_q, addr_d;
   word_t store_q, store_d;
   word_t load_q, load_d;
   logic  wb_valid_q, wb_valid_d;
   logic  halt_q, halt_d;
   logic  err_q, err_d;
   logic  stall;
   logic  cnt_en, cnt_clr, cnt_at_max;

   sat_counter #(.W(CNT_W)) u_watchdog (
      .clk_i    (clk_i),
      .nrst_i   (nrst_i),
      .en_i     (cnt_en),
      .clr_i    (cnt_clr),
      .max_i    (CNT_W'(TIMEOUT_CYCLES)),
      .at_max_o (cnt_at_max)
   );

   always_comb begin
      state_d    = state_q;
      ren_d      = ren_q;
      wen_d      = wen_q;
      addr_d     = addr_q;
      store_d    = store_q;
      load_d     = load_q;
      wb_valid_d = 1'b0;
      halt_d     = halt_q;
      err_d      = err_q;
      stall      = 1'b0;
      cnt_en     = 1'b0;
      cnt_clr    = 1'b1;
      case (state_q)
         IDLE: begin
            if (ex_valid_i) begin
               if (ex_halt_i) begin
                  state_d = HALTED;
                  halt_d  = 1'b1;
               end else if (is_mem_op(ex_memRd_i, ex_memWr_i)) begin
                  state_d = ACCESS;
                  addr_d  = ex_addr_i;
                  store_d = ex_wdat_i;
                  ren_d   = ex_memRd_i & ~ex_memWr_i;
                  wen_d   = ex_memWr_i;
                  stall   = 1'b1;
                  if (ex_memRd_i && ex_memWr_i) begin
                     err_d = 1'b1;
                  end
               end else begin
                  wb_valid_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (dhit_i) begin
               if (ren_q) begin
                  load_d = dcache_load_i;
               end
               ren_d      = 1'b0;
               wen_d      = 1'b0;
               wb_valid_d = 1'b1;
               state_d    = IDLE;
            end else begin
               // keep waiting past the watchdog; the error is only reported
               stall   = 1'b1;
               cnt_en  = 1'b1;
               cnt_clr = 1'b0;
               if (cnt_at_max) begin
                  err_d = 1'b1;
               end
            end
         end
         HALTED: begin
            stall  = 1'b1;
            ren_d  = 1'b0;
            wen_d  = 1'b0;
            halt_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q    <= IDLE;
         ren_q      <= 1'b0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         load_q     <= '0;
         wb_valid_q <= 1'b0;
         halt_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ren_q      <= ren_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         store_q    <= store_d;
         load_q     <= load_d;
         wb_valid_q <= wb_valid_d;
         halt_q     <= halt_d;
         err_q      <= err_d;
      end
   end

   assign dmemREN_o     = ren_q;
   assign dmemWEN_o     = wen_q;
   assign dmemaddr_o    = addr_q;
   assign dmemstore_o   = store_q;
   assign dmemload_in_o = load_q;
   assign wb_valid_o    = wb_valid_q;
   assign halt_in_o     = halt_q;
   assign mem_err_o     = err_q;
   assign mem_stall_o   = stall;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short watchdog (TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

   logic        clk_i = 1'b0;
   logic        nrst_i;
   logic        ex_valid_i, ex_memRd_i, ex_memWr_i, ex_halt_i;
   logic [31:0] ex_addr_i, ex_wdat_i;
   logic        dhit_i;
   logic [31:0] dcache_load_i;
   logic        dmemREN_o, dmemWEN_o, wb_valid_o, mem_stall_o, halt_in_o, mem_err_o;
   logic [31:0] dmemaddr_o, dmemstore_o, dmemload_in_o;

   int n_chk  = 0;
   int n_pass = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
      .clk_i         (clk_i),
      .nrst_i        (nrst_i),
      .ex_valid_i    (ex_valid_i),
      .ex_memRd_i    (ex_memRd_i),
      .ex_memWr_i    (ex_memWr_i),
      .ex_addr_i     (ex_addr_i),
      .ex_wdat_i     (ex_wdat_i),
      .ex_halt_i     (ex_halt_i),
      .dhit_i        (dhit_i),
      .dcache_load_i (dcache_load_i),
      .dmemREN_o     (dmemREN_o),
      .dmemWEN_o     (dmemWEN_o),
      .dmemaddr_o    (dmemaddr_o),
      .dmemstore_o   (dmemstore_o),
      .dmemload_in_o (dmemload_in_o),
      .wb_valid_o    (wb_valid_o),
      .mem_stall_o   (mem_stall_o),
      .halt_in_o     (halt_in_o),
      .mem_err_o     (mem_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic h);
      ex_valid_i = v;
      ex_memRd_i = rd;
      ex_memWr_i = wr;
      ex_addr_i  = a;
      ex_wdat_i  = d;
      ex_halt_i  = h;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ren"},   {31'b0, dmemREN_o},  32'h0);
      chk({tag, "_wen"},   {31'b0, dmemWEN_o},  32'h0);
      chk({tag, "_addr"},  dmemaddr_o,          32'h0);
      chk({tag, "_store"}, dmemstore_o,         32'h0);
      chk({tag, "_load"},  dmemload_in_o,       32'h0);
      chk({tag, "_wb"},    {31'b0, wb_valid_o}, 32'h0);
      chk({tag, "_halt"},  {31'b0, halt_in_o},  32'h0);
      chk({tag, "_err"},   {31'b0, mem_err_o},  32'h0);
   endtask

   initial begin
      nrst_i = 1'b0;
      dhit_i = 1'b0;
      dcache_load_i = 32'h0;
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      repeat (2) tick();
      chk_reset_outs("rst");
      chk("rst_stall", {31'b0, mem_stall_o}, 32'h0);

      // load 0x100, dhit on third ACCESS cycle
      nrst_i = 1'b1;
      set_ex(1, 1, 0, 32'h100, 32'h0, 0);
      #1 chk("ld_acc_stall", {31'b0, mem_stall_o}, 32'h1);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      chk("ld_ren1", {31'b0, dmemREN_o}, 32'h1);
      chk("ld_wen1", {31'b0, dmemWEN_o}, 32'h0);
      chk("ld_addr", dmemaddr_o, 32'h100);
      #1 chk("ld_stall1", {31'b0, mem_stall_o}, 32'h1);
      tick();
      chk("ld_ren2", {31'b0, dmemREN_o}, 32'h1);
      chk("ld_wb2", {31'b0, wb_valid_o}, 32'h0);
      #1 chk("ld_stall2", {31'b0, mem_stall_o}, 32'h1);
      tick();
      chk("ld_ren3", {31'b0, dmemREN_o}, 32'h1);
      dhit_i = 1'b1;
      dcache_load_i = 32'hDEADBEEF;
      #1 chk("ld_stall3", {31'b0, mem_stall_o}, 32'h0);
      tick();
      dhit_i = 1'b0;
      chk("ld_ren_off", {31'b0, dmemREN_o}, 32'h0);
      chk("ld_data", dmemload_in_o, 32'hDEADBEEF);
      chk("ld_wb", {31'b0, wb_valid_o}, 32'h1);
      tick();
      chk("ld_wb_once", {31'b0, wb_valid_o}, 32'h0);

      // store 0x200, dhit on first ACCESS cycle
      set_ex(1, 0, 1, 32'h200, 32'h12345678, 0);
      #1 chk("st_acc_stall", {31'b0, mem_stall_o}, 32'h1);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      chk("st_wen", {31'b0, dmemWEN_o}, 32'h1);
      chk("st_ren", {31'b0, dmemREN_o}, 32'h0);
      chk("st_addr", dmemaddr_o, 32'h200);
      chk("st_data", dmemstore_o, 32'h12345678);
      dhit_i = 1'b1;
      dcache_load_i = 32'h55555555;
      #1 chk("st_stall", {31'b0, mem_stall_o}, 32'h0);
      tick();
      dhit_i = 1'b0;
      chk("st_wen_off", {31'b0, dmemWEN_o}, 32'h0);
      chk("st_wb", {31'b0, wb_valid_o}, 32'h1);
      chk("st_load_kept", dmemload_in_o, 32'hDEADBEEF);
      chk("st_err", {31'b0, mem_err_o}, 32'h0);

      // non-memory op: no stall, wb_valid next cycle
      set_ex(1, 0, 0, 32'h0, 32'h0, 0);
      #1 chk("nm_stall", {31'b0, mem_stall_o}, 32'h0);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      chk("nm_wb", {31'b0, wb_valid_o}, 32'h1);
      chk("nm_ren", {31'b0, dmemREN_o}, 32'h0);
      tick();
      chk("nm_wb_once", {31'b0, wb_valid_o}, 32'h0);

      // back-to-back loads 0x0 then 0x4, each hit on first ACCESS cycle
      set_ex(1, 1, 0, 32'h0, 32'h0, 0);
      tick();
      chk("bb_ren_a", {31'b0, dmemREN_o}, 32'h1);
      chk("bb_addr_a", dmemaddr_o, 32'h0);
      dhit_i = 1'b1;
      dcache_load_i = 32'h11111111;
      #1 chk("bb_stall_a", {31'b0, mem_stall_o}, 32'h0);
      tick();
      set_ex(1, 1, 0, 32'h4, 32'h0, 0);
      dhit_i = 1'b0;
      chk("bb_wb_a", {31'b0, wb_valid_o}, 32'h1);
      chk("bb_data_a", dmemload_in_o, 32'h11111111);
      #1 chk("bb_acc_stall_b", {31'b0, mem_stall_o}, 32'h1);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      chk("bb_wb_gap", {31'b0, wb_valid_o}, 32'h0);
      chk("bb_addr_b", dmemaddr_o, 32'h4);
      dhit_i = 1'b1;
      dcache_load_i = 32'h22222222;
      #1 chk("bb_stall_b", {31'b0, mem_stall_o}, 32'h0);
      tick();
      dhit_i = 1'b0;
      chk("bb_wb_b", {31'b0, wb_valid_o}, 32'h1);
      chk("bb_data_b", dmemload_in_o, 32'h22222222);

      // read and write both set: write wins, sticky error
      set_ex(1, 1, 1, 32'h300, 32'hA5A5A5A5, 0);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      chk("rw_wen", {31'b0, dmemWEN_o}, 32'h1);
      chk("rw_ren", {31'b0, dmemREN_o}, 32'h0);
      chk("rw_err", {31'b0, mem_err_o}, 32'h1);
      dhit_i = 1'b1;
      tick();
      dhit_i = 1'b0;
      chk("rw_wb", {31'b0, wb_valid_o}, 32'h1);
      chk("rw_load_kept", dmemload_in_o, 32'h22222222);
      tick();
      chk("rw_err_sticky", {31'b0, mem_err_o}, 32'h1);
      nrst_i = 1'b0;
      tick();
      nrst_i = 1'b1;
      chk("rw_err_clr", {31'b0, mem_err_o}, 32'h0);

      // watchdog: error after 4 ACCESS cycles without dhit, request held, late hit completes
      set_ex(1, 1, 0, 32'h400, 32'h0, 0);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("wd_err_c%0d", k), {31'b0, mem_err_o}, (k >= 5) ? 32'h1 : 32'h0);
         chk($sformatf("wd_ren_c%0d", k), {31'b0, dmemREN_o}, 32'h1);
         chk($sformatf("wd_addr_c%0d", k), dmemaddr_o, 32'h400);
         #1 chk($sformatf("wd_stall_c%0d", k), {31'b0, mem_stall_o}, 32'h1);
         tick();
      end
      dhit_i = 1'b1;
      dcache_load_i = 32'hCAFEF00D;
      #1 chk("wd_late_stall", {31'b0, mem_stall_o}, 32'h0);
      tick();
      dhit_i = 1'b0;
      chk("wd_late_wb", {31'b0, wb_valid_o}, 32'h1);
      chk("wd_late_data", dmemload_in_o, 32'hCAFEF00D);
      chk("wd_err_kept", {31'b0, mem_err_o}, 32'h1);

      // reset mid-ACCESS drops the request
      set_ex(1, 1, 0, 32'h500, 32'h0, 0);
      tick();
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      chk("mr_ren", {31'b0, dmemREN_o}, 32'h1);
      nrst_i = 1'b0;
      dhit_i = 1'b1;
      tick();
      chk_reset_outs("mr");
      nrst_i = 1'b1;
      dhit_i = 1'b0;
      tick();
      chk("mr_no_wb", {31'b0, wb_valid_o}, 32'h0);
      chk("mr_no_ren", {31'b0, dmemREN_o}, 32'h0);

      // HALT is absorbing; requests and dhit ignored until reset
      set_ex(1, 0, 0, 32'h0, 32'h0, 1);
      #1 chk("h_acc_stall", {31'b0, mem_stall_o}, 32'h0);
      tick();
      set_ex(1, 1, 0, 32'h600, 32'h0, 0);
      dhit_i = 1'b1;
      chk("h_halt", {31'b0, halt_in_o}, 32'h1);
      #1 chk("h_stall", {31'b0, mem_stall_o}, 32'h1);
      tick();
      tick();
      chk("h_ren", {31'b0, dmemREN_o}, 32'h0);
      chk("h_addr", dmemaddr_o, 32'h0);
      chk("h_wb", {31'b0, wb_valid_o}, 32'h0);
      chk("h_halt_kept", {31'b0, halt_in_o}, 32'h1);
      chk("h_stall_kept", {31'b0, mem_stall_o}, 32'h1);
      set_ex(0, 0, 0, 32'h0, 32'h0, 0);
      dhit_i = 1'b0;
      nrst_i = 1'b0;
      tick();
      nrst_i = 1'b1;
      chk("h_rst_halt", {31'b0, halt_in_o}, 32'h0);
      #1 chk("h_rst_stall", {31'b0, mem_stall_o}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
